// File: rtl/sha256_round_engine.sv
// sha256_round_engine
// Iterative SHA-256 compression engine. It loads 16 message words per block
// over a valid/ready stream, runs 64 rounds at UNROLL rounds per clock, chains
// H across blocks and publishes the digest with a one-cycle valid pulse.
// SHA-224 (its IV and the truncated digest) is built only when the macro
// SHA256_RE_SHA224_EN is defined. Otherwise mode_224 is ignored.

module sha256_round_engine #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [31:0]  msg_word,
    input  logic         msg_first,
    input  logic         mode_224,
    output logic         busy,
    output logic         digest_valid,
    output logic [255:0] digest
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
        $error("sha256_round_engine: UNROLL must be 1, 2 or 4");
    end

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [5:0] RND_STEP = 6'(UNROLL);
    localparam logic [5:0] RND_LAST = 6'(64 - UNROLL);

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    logic [1:0]   state;
    logic [3:0]   cnt;
    logic [5:0]   rnd;
    logic [31:0]  h_reg   [8];
    logic [31:0]  wv      [8];   // working variables a..h
    logic [31:0]  w       [16];  // message schedule window, w[0] = W[t]
    logic [31:0]  w_ext   [16 + UNROLL];
    logic [31:0]  w_next  [16];
    logic [31:0]  wv_next [8];
    logic [31:0]  h_sum   [8];
    logic [31:0]  start_iv [8];
    logic [31:0]  t1;
    logic [31:0]  t2;
    logic [5:0]   k_idx;
    logic [255:0] digest_next;
    logic         word_take;
    logic         start_new;

    assign msg_ready = (state == S_LOAD);
    assign busy      = (state == S_ROUND) || (state == S_FINAL);
    assign word_take = msg_ready && msg_valid;
    assign start_new = word_take && (cnt == 4'd0) && msg_first;

`ifdef SHA256_RE_SHA224_EN
    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    logic mode;

    // Mode is latched with word 0 of a new message and survives chained blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= 1'b0;
        end else if (clear) begin
            mode <= 1'b0;
        end else if (start_new) begin
            mode <= mode_224;
        end
    end

    // Starting IV follows the mode requested alongside word 0.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            start_iv[i] = mode_224 ? IV224[i] : IV256[i];
        end
    end
`else
    logic unused_mode_224;
    assign unused_mode_224 = mode_224;

    // Only the SHA-256 IV exists in this build.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            start_iv[i] = IV256[i];
        end
    end
`endif

    // Expand the schedule by UNROLL words; later new words may depend on earlier ones.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a value on every path (here a full
        // default first), otherwise synthesis infers a latch to hold the stale value.
        for (int i = 0; i < 16 + UNROLL; i++) begin
            w_ext[i] = (i < 16) ? w[i] : 32'h0;
        end
        for (int j = 0; j < UNROLL; j++) begin
            w_ext[16 + j] = small_sigma1(w_ext[14 + j]) + w_ext[9 + j]
                          + small_sigma0(w_ext[1 + j]) + w_ext[j];
        end
        for (int i = 0; i < 16; i++) begin
            w_next[i] = w_ext[i + UNROLL];
        end
    end

    // UNROLL chained compression rounds t = rnd .. rnd+UNROLL-1.
    always_comb begin
        t1    = 32'h0;
        t2    = 32'h0;
        k_idx = rnd;
        for (int i = 0; i < 8; i++) begin
            wv_next[i] = wv[i];
        end
        for (int j = 0; j < UNROLL; j++) begin
            k_idx = rnd + 6'(j);
            t1 = wv_next[7] + big_sigma1(wv_next[4]) + ch(wv_next[4], wv_next[5], wv_next[6])
               + K_ROM[k_idx] + w_ext[j];
            t2 = big_sigma0(wv_next[0]) + maj(wv_next[0], wv_next[1], wv_next[2]);
            wv_next[7] = wv_next[6];
            wv_next[6] = wv_next[5];
            wv_next[5] = wv_next[4];
            wv_next[4] = wv_next[3] + t1;
            wv_next[3] = wv_next[2];
            wv_next[2] = wv_next[1];
            wv_next[1] = wv_next[0];
            wv_next[0] = t1 + t2;
        end
    end

    // Chaining sum and output formatting (SHA-224 zeroes the last word).
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            h_sum[i] = h_reg[i] + wv[i];
            digest_next[255 - 32 * i -: 32] = h_sum[i];
        end
`ifdef SHA256_RE_SHA224_EN
        if (mode) begin
            digest_next[31:0] = 32'h0;
        end
`endif
    end

    // Control FSM, chaining value and published digest.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // pre-edge values, independent of statement order.
        if (!rst_n) begin
            state        <= S_LOAD;
            cnt          <= 4'd0;
            rnd          <= 6'd0;
            digest       <= 256'h0;
            digest_valid <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_reg[i] <= IV256[i];
            end
        end else if (clear) begin
            state        <= S_LOAD;
            cnt          <= 4'd0;
            rnd          <= 6'd0;
            digest_valid <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_reg[i] <= IV256[i];
            end
        end else begin
            digest_valid <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (word_take) begin
                        cnt <= cnt + 4'd1;
                        if (start_new) begin
                            for (int i = 0; i < 8; i++) begin
                                h_reg[i] <= start_iv[i];
                            end
                        end
                        if (cnt == 4'd15) begin
                            state <= S_ROUND;
                            rnd   <= 6'd0;
                        end
                    end
                end
                S_ROUND: begin
                    rnd <= rnd + RND_STEP;
                    if (rnd == RND_LAST) begin
                        state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        h_reg[i] <= h_sum[i];
                    end
                    digest       <= digest_next;
                    digest_valid <= 1'b1;
                    state        <= S_DONE;
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

    // Schedule window and working variables: loaded in LOAD, advanced in ROUND.
    always_ff @(posedge clk) begin
        // NOTE: this datapath storage is deliberately not reset; every entry is written
        // before the rounds read it, so a reset would only add fan-out.
        if (state == S_LOAD) begin
            if (word_take) begin
                w[cnt] <= msg_word;
                if (cnt == 4'd15) begin
                    for (int i = 0; i < 8; i++) begin
                        wv[i] <= h_reg[i];
                    end
                end
            end
        end else if (state == S_ROUND) begin
            for (int i = 0; i < 16; i++) begin
                w[i] <= w_next[i];
            end
            for (int i = 0; i < 8; i++) begin
                wv[i] <= wv_next[i];
            end
        end
    end

endmodule

// File: tb/tb_sha256_round_engine.sv
// tb_sha256_round_engine
// Directed bench for sha256_round_engine using known-answer digests. It also
// checks handshake timing, the single-cycle digest pulse, clear and async reset.
// Build with SHA256_RE_SHA224_EN to expect the truncated SHA-224 result.

module tb_sha256_round_engine;

    parameter int UNROLL = 1;
    localparam int LAT = 64 / UNROLL + 2;

    localparam logic [255:0] DIG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_TWO =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
`ifdef SHA256_RE_SHA224_EN
    localparam logic [255:0] DIG_224 =
        {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
`else
    localparam logic [255:0] DIG_224 = DIG_ABC;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         msg_valid = 1'b0;
    logic         msg_first = 1'b0;
    logic         mode_224 = 1'b0;
    logic [31:0]  msg_word = 32'h0;
    logic         msg_ready;
    logic         busy;
    logic         digest_valid;
    logic [255:0] digest;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cyc = 0;
    int dv_cyc = 0;

    logic [31:0] blk_abc   [16];
    logic [31:0] blk_empty [16];
    logic [31:0] blk_two1  [16];
    logic [31:0] blk_two2  [16];

    sha256_round_engine #(.UNROLL(UNROLL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .msg_word     (msg_word),
        .msg_first    (msg_first),
        .mode_224     (mode_224),
        .busy         (busy),
        .digest_valid (digest_valid),
        .digest       (digest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Feed one block; optional random idle cycles on msg_valid.
    task automatic send_block(input logic [31:0] blk [16], input logic first,
                              input logic m224, input bit gaps);
        int i;
        int guard;
        i = 0;
        guard = 0;
        @(posedge clk);
        #1;
        while (i < 16 && guard < 1000) begin
            if (gaps && $urandom_range(0, 1) == 0) begin
                msg_valid = 1'b0;
            end else begin
                msg_valid = 1'b1;
                msg_word  = blk[i];
                msg_first = (i == 0) ? first : 1'b0;
                mode_224  = m224;
            end
            @(negedge clk);
            if (msg_valid && msg_ready) begin
                i++;
                if (i == 16) last_cyc = cyc;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        msg_valid = 1'b0;
        msg_first = 1'b0;
        check("send_words_accepted", 256'(i), 256'd16);
    endtask

    // Wait for the digest pulse, checking ready stays low, latency and pulse width.
    task automatic wait_digest(input string tag, input bit poke, input bit chk_dig,
                               input logic [255:0] exp);
        bit ready_seen;
        bit got_dv;
        logic [255:0] dig_q;
        ready_seen = 1'b0;
        got_dv     = 1'b0;
        dig_q      = '0;
        if (poke) begin
            msg_valid = 1'b1;
            msg_first = 1'b1;
            msg_word  = 32'hdeadbeef;
        end
        for (int n = 0; n < 200 && !got_dv; n++) begin
            @(negedge clk);
            if (msg_ready) ready_seen = 1'b1;
            if (digest_valid) begin
                got_dv = 1'b1;
                dv_cyc = cyc;
                dig_q  = digest;
            end
        end
        msg_valid = 1'b0;
        msg_first = 1'b0;
        check({tag, "_dv_seen"}, 256'(got_dv), 256'd1);
        check({tag, "_ready_low"}, 256'(ready_seen), 256'd0);
        check({tag, "_latency"}, 256'(dv_cyc - last_cyc), 256'(LAT));
        if (chk_dig) check({tag, "_digest"}, dig_q, exp);
        @(negedge clk);
        check({tag, "_pulse_end"}, 256'(digest_valid), 256'd0);
        check({tag, "_ready_back"}, 256'(msg_ready), 256'd1);
    endtask

    initial begin
        int dv_count;
        for (int i = 0; i < 16; i++) begin
            blk_abc[i]   = 32'h0;
            blk_empty[i] = 32'h0;
            blk_two1[i]  = 32'h0;
            blk_two2[i]  = 32'h0;
        end
        blk_abc[0]   = 32'h61626380;
        blk_abc[15]  = 32'h00000018;
        blk_empty[0] = 32'h80000000;
        blk_two1[0]  = 32'h61626364; blk_two1[1]  = 32'h62636465;
        blk_two1[2]  = 32'h63646566; blk_two1[3]  = 32'h64656667;
        blk_two1[4]  = 32'h65666768; blk_two1[5]  = 32'h66676869;
        blk_two1[6]  = 32'h6768696a; blk_two1[7]  = 32'h68696a6b;
        blk_two1[8]  = 32'h696a6b6c; blk_two1[9]  = 32'h6a6b6c6d;
        blk_two1[10] = 32'h6b6c6d6e; blk_two1[11] = 32'h6c6d6e6f;
        blk_two1[12] = 32'h6d6e6f70; blk_two1[13] = 32'h6e6f7071;
        blk_two1[14] = 32'h80000000;
        blk_two2[15] = 32'h000001c0;

        // Reset state.
        #12;
        check("rst_ready", 256'(msg_ready), 256'd1);
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_dv", 256'(digest_valid), 256'd0);
        check("rst_digest", digest, 256'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Case 1: "abc", producer keeps valid high while the engine is busy.
        send_block(blk_abc, 1'b1, 1'b0, 1'b0);
        check("abc_busy", 256'(busy), 256'd1);
        wait_digest("abc", 1'b1, 1'b1, DIG_ABC);

        // Case 2: empty message.
        send_block(blk_empty, 1'b1, 1'b0, 1'b0);
        wait_digest("empty", 1'b0, 1'b1, DIG_EMPTY);

        // Case 3: two chained blocks, one pulse per block.
        send_block(blk_two1, 1'b1, 1'b0, 1'b0);
        wait_digest("two_b1", 1'b0, 1'b0, 256'h0);
        send_block(blk_two2, 1'b0, 1'b0, 1'b0);
        wait_digest("two_b2", 1'b0, 1'b1, DIG_TWO);

        // Case 4: SHA-224 request (plain SHA-256 result when the feature is absent).
        send_block(blk_abc, 1'b1, 1'b1, 1'b0);
        wait_digest("sha224", 1'b0, 1'b1, DIG_224);

        // Case 5: random valid gaps, back to SHA-256 mode.
        send_block(blk_abc, 1'b1, 1'b0, 1'b1);
        wait_digest("gaps", 1'b0, 1'b1, DIG_ABC);

        // Case 6a: clear during ROUND cycle 10.
        send_block(blk_abc, 1'b1, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check("clr_ready", 256'(msg_ready), 256'd1);
        check("clr_busy", 256'(busy), 256'd0);
        dv_count = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (digest_valid) dv_count++;
        end
        check("clr_no_dv", 256'(dv_count), 256'd0);
        check("clr_digest_held", digest, DIG_ABC);

        // Case 6b: async reset in the middle of loading a block.
        @(posedge clk);
        #1;
        msg_valid = 1'b1;
        msg_first = 1'b1;
        msg_word  = 32'h80000000;
        @(posedge clk);
        #1;
        msg_first = 1'b0;
        msg_word  = 32'h0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_digest", digest, 256'h0);
        check("arst_ready", 256'(msg_ready), 256'd1);
        check("arst_dv", 256'(digest_valid), 256'd0);
        msg_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_block(blk_abc, 1'b1, 1'b0, 1'b0);
        wait_digest("post_rst", 1'b0, 1'b1, DIG_ABC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
